exp6_exibe_sequencia: RTL and testbench



---
 rtl/exp6_exibe_sequencia_if.sv | 12 +
 rtl/exp6_exibe_sequencia.sv | 126 ++++++++++++
 tb/tb_exp6_exibe_sequencia.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exp6_exibe_sequencia_if.sv
// rtl/exp6_exibe_sequencia_if.sv - sequence memory read bus between display FSM and memory
interface exp6_exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado;

  // The display FSM drives the address; the memory answers combinationally.
  modport master (output mem_endereco, input mem_dado);
  modport slave  (input mem_endereco, output mem_dado);
endinterface

// File: rtl/exp6_exibe_sequencia.sv
// rtl/exp6_exibe_sequencia.sv - shows stored moves 0..limite on the LEDs; optional EXIBE_PAUSA_EN adds a pausa input
module exp6_exibe_sequencia #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 500,
  parameter int T_OFF  = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
`ifdef EXIBE_PAUSA_EN
  input  logic              pausa,
`endif
  exp6_exibe_sequencia_if.master mem,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] TON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] TOFF_LAST = TW'(T_OFF - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    PREPARA = 4'h1,
    CARREGA = 4'h2,
    ACENDE  = 4'h3,
    APAGA   = 4'h4,
    PROXIMO = 4'h5,
    FIM     = 4'hF
  } estado_t;

  estado_t           estado;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] limite_reg;
  logic              congela;

  // Freezing only matters in the lit/blank phases; elsewhere it is ignored.
`ifdef EXIBE_PAUSA_EN
  assign congela = pausa;
`else
  assign congela = 1'b0;
`endif

  assign mem.mem_endereco = endereco;
  assign db_estado        = estado;

  // Display sequencer: state, timer, address and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      timer      <= '0;
      endereco   <= '0;
      limite_reg <= '0;
      leds       <= '0;
      exibindo   <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado   <= PREPARA;
            exibindo <= 1'b1;
          end
        end
        PREPARA: begin
          endereco   <= '0;
          timer      <= '0;
          limite_reg <= limite;
          estado     <= CARREGA;
        end
        CARREGA: begin
          leds   <= mem.mem_dado;
          timer  <= '0;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (!congela) begin
            if (timer == TON_LAST) begin
              timer  <= '0;
              leds   <= '0;
              estado <= APAGA;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        APAGA: begin
          if (!congela) begin
            if (timer == TOFF_LAST) begin
              timer <= '0;
              if (endereco == limite_reg) begin
                estado   <= FIM;
                exibindo <= 1'b0;
                pronto   <= 1'b1;
              end else begin
                estado <= PROXIMO;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        PROXIMO: begin
          endereco <= endereco + 1'b1;
          estado   <= CARREGA;
        end
        FIM: begin
          estado <= OCIOSO;
        end
        default: begin
          estado   <= OCIOSO;
          exibindo <= 1'b0;
          leds     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp6_exibe_sequencia.sv
// tb/tb_exp6_exibe_sequencia.sv - self-checking bench for exp6_exibe_sequencia
module tb_exp6_exibe_sequencia;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;
  localparam int BLOCO  = T_ON + T_OFF + 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              iniciar = 1'b0;
  logic [ADDR_W-1:0] limite = '0;
  logic [DATA_W-1:0] leds;
  logic              exibindo;
  logic              pronto;
  logic [3:0]        db_estado;
`ifdef EXIBE_PAUSA_EN
  logic              pausa = 1'b0;
`endif
  logic [DATA_W-1:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  exp6_exibe_sequencia_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  assign bus.mem_dado = mem[bus.mem_endereco];

  exp6_exibe_sequencia #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ON(T_ON), .T_OFF(T_OFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .limite(limite),
`ifdef EXIBE_PAUSA_EN
    .pausa(pausa),
`endif
    .mem(bus),
    .leds(leds),
    .exibindo(exibindo),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lim;
    bit all_ones;
    bit segura;
    int troca_k;
    int lat;
  } vet_t;

  task automatic chk(input string nome, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  function automatic int fim_k(input int L);
    return 1 + (L + 1) * (1 + T_ON + T_OFF) + L;
  endfunction

  // Expected outputs k cycles after the first prepara cycle, from the timing rules.
  task automatic modelo(input int k, input int L, output int e_leds, output int e_addr,
                        output int e_exib, output int e_pronto, output int e_st);
    int p, e, r;
    e_leds = 0; e_addr = -1; e_exib = 0; e_pronto = 0; e_st = 0;
    if (k == 0) begin
      e_st = 1; e_exib = 1;
    end else if (k == fim_k(L)) begin
      e_st = 15; e_addr = L; e_pronto = 1;
    end else if (k < fim_k(L)) begin
      p = k - 1; e = p / BLOCO; r = p % BLOCO;
      e_addr = e; e_exib = 1;
      if (r == 0) e_st = 2;
      else if (r <= T_ON) begin e_st = 3; e_leds = int'(mem[e[3:0]]); end
      else if (r <= T_ON + T_OFF) e_st = 4;
      else e_st = 5;
    end
  endtask

  // Starts a display and checks every cycle; abort_k>=0 asserts reset at that cycle.
  task automatic exibir(input int L, input int lat, input bit segura, input int troca_k,
                        input int abort_k);
    int got, el, ea, ex, ep, es;
    got = -1;
    limite = L[ADDR_W-1:0];
    iniciar = 1'b1;
    ciclo();
    if (!segura) iniciar = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      modelo(k, L, el, ea, ex, ep, es);
      chk($sformatf("leds k=%0d", k), int'(leds), el);
      chk($sformatf("estado k=%0d", k), int'(db_estado), es);
      chk($sformatf("exibindo k=%0d", k), int'(exibindo), ex);
      chk($sformatf("pronto k=%0d", k), int'(pronto), ep);
      if (ea >= 0) chk($sformatf("endereco k=%0d", k), int'(bus.mem_endereco), ea);
      if (k == abort_k) begin
        reset = 1'b0;
        return;
      end
      if (pronto) begin
        got = k;
        break;
      end
      if (k == troca_k) limite = 4'd1;
      ciclo();
    end
    chk("latencia", got, lat);
  endtask

  task automatic drenar();
    int n;
    n = 0;
    while (db_estado != 4'h0 && n < 400) begin
      ciclo();
      n++;
    end
    chk("drenar ocioso", int'(db_estado), 0);
  endtask

  task automatic carrega_mem(input bit all_ones);
    for (int i = 0; i < 16; i++) mem[i] = all_ones ? 4'hF : 4'h0;
    if (!all_ones) begin
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
    end
  endtask

  initial begin
    vet_t tab [4];
    int L;
    tab[0] = '{lim: 0,  all_ones: 1'b0, segura: 1'b0, troca_k: -1, lat: 8};
    tab[1] = '{lim: 3,  all_ones: 1'b0, segura: 1'b0, troca_k: -1, lat: 32};
    tab[2] = '{lim: 3,  all_ones: 1'b0, segura: 1'b1, troca_k: 10, lat: 32};
    tab[3] = '{lim: 15, all_ones: 1'b1, segura: 1'b0, troca_k: -1, lat: 128};
    carrega_mem(1'b0);

    repeat (2) @(posedge clock);
    #1;
    chk("reset leds", int'(leds), 0);
    chk("reset endereco", int'(bus.mem_endereco), 0);
    chk("reset exibindo", int'(exibindo), 0);
    chk("reset pronto", int'(pronto), 0);
    chk("reset estado", int'(db_estado), 0);
    reset = 1'b1;
    ciclo();
    chk("ocioso sem iniciar", int'(db_estado), 0);

    for (int i = 0; i < 4; i++) begin
      carrega_mem(tab[i].all_ones);
      exibir(tab[i].lim, tab[i].lat, tab[i].segura, tab[i].troca_k, -1);
      ciclo();
      chk($sformatf("volta ocioso %0d", i), int'(db_estado), 0);
      chk($sformatf("pronto unico %0d", i), int'(pronto), 0);
      if (tab[i].segura) begin
        ciclo();
        chk("reinicio so apos ocioso", int'(db_estado), 1);
        iniciar = 1'b0;
        drenar();
      end
    end

    carrega_mem(1'b0);
    exibir(3, -1, 1'b0, -1, 19);
    #1;
    chk("abort leds", int'(leds), 0);
    chk("abort exibindo", int'(exibindo), 0);
    chk("abort estado", int'(db_estado), 0);
    chk("abort endereco", int'(bus.mem_endereco), 0);
    for (int i = 0; i < 3; i++) begin
      ciclo();
      chk("abort sem pronto", int'(pronto), 0);
    end
    reset = 1'b1;
    ciclo();
    exibir(1, 16, 1'b0, -1, -1);
    ciclo();

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << $urandom_range(0, 3);
      L = $urandom_range(0, 7);
      repeat ($urandom_range(0, 3)) ciclo();
      exibir(L, fim_k(L), 1'b0, $urandom_range(1, 30), -1);
      ciclo();
      chk("aleatorio ocioso", int'(db_estado), 0);
    end

`ifdef EXIBE_PAUSA_EN
    begin
      int acesos, got;
      acesos = 0; got = -1;
      carrega_mem(1'b0);
      limite = '0;
      iniciar = 1'b1;
      ciclo();
      iniciar = 1'b0;
      for (int k = 0; k <= 200; k++) begin
        if (leds != 0) acesos++;
        if (pronto) begin got = k; break; end
        if (k == 3) pausa = 1'b1;
        if (k == 13) pausa = 1'b0;
        ciclo();
      end
      chk("pausa acesos", acesos, 14);
      chk("pausa latencia", got, 18);
      ciclo();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
